// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - MEM-stage data-memory access controller with misalign detect and watchdog
module dmem_access_ctrl #(
   parameter int          TIMEOUT   = 16,
   parameter logic [31:0] RDATA_ERR = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        MemRead_i,
   input  logic        MemWrite_i,
   input  logic [31:0] MemAddr_i,
   input  logic [31:0] MemWrite_Data_i,
   output logic        stall_o,
   output logic [31:0] MemRead_Data_o,
   output logic        misalign_o,
   output logic        err_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t     state, state_nxt;
   logic [7:0] cnt;
   logic       access, aligned, timeout_hit;

   assign access      = MemRead_i | MemWrite_i;
   assign aligned     = (MemAddr_i[1:0] == 2'b00);
   assign timeout_hit = (cnt == 8'(TIMEOUT - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      stall_o   = 1'b0;
      case (state)
         IDLE: begin
            if (access && aligned) begin
               stall_o   = 1'b1;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            stall_o = 1'b1;
            if (mem_ack_i || timeout_hit) state_nxt = DONE;
         end
         // DONE releases the pipeline; its inputs still describe the finished access.
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt            <= 8'd0;
         mem_req_o      <= 1'b0;
         mem_we_o       <= 1'b0;
         mem_addr_o     <= 32'd0;
         mem_wdata_o    <= 32'd0;
         misalign_o     <= 1'b0;
         err_o          <= 1'b0;
         MemRead_Data_o <= 32'd0;
      end else begin
         misalign_o <= 1'b0;
         case (state)
            IDLE: begin
               if (access) begin
                  if (aligned) begin
                     mem_req_o   <= 1'b1;
                     mem_we_o    <= MemWrite_i;
                     mem_addr_o  <= {MemAddr_i[31:2], 2'b00};
                     mem_wdata_o <= MemWrite_Data_i;
                     cnt         <= 8'd0;
                  end else begin
                     misalign_o <= 1'b1;
                     if (!MemWrite_i) MemRead_Data_o <= RDATA_ERR;
                  end
               end
            end
            BUSY: begin
               // Ack is tested first so a same-cycle ack beats the watchdog.
               if (mem_ack_i) begin
                  mem_req_o <= 1'b0;
                  cnt       <= 8'd0;
                  if (!mem_we_o) MemRead_Data_o <= mem_rdata_i;
               end else if (timeout_hit) begin
                  mem_req_o <= 1'b0;
                  err_o     <= 1'b1;
                  cnt       <= 8'd0;
                  if (!mem_we_o) MemRead_Data_o <= RDATA_ERR;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - directed self-checking bench for dmem_access_ctrl
module tb_dmem_access_ctrl;

   localparam logic [31:0] ERR = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rd = 1'b0, wr = 1'b0, ack = 1'b0;
   logic [31:0] addr = 32'd0, wdata = 32'd0, rdata = 32'd0;
   logic        stall, misalign, err, req, we;
   logic [31:0] rd_data, maddr, mwdata;

   int total = 0;
   int bad   = 0;

   dmem_access_ctrl #(.TIMEOUT(4), .RDATA_ERR(ERR)) dut (
      .clk_i(clk), .rst_i(rst),
      .MemRead_i(rd), .MemWrite_i(wr), .MemAddr_i(addr), .MemWrite_Data_i(wdata),
      .stall_o(stall), .MemRead_Data_o(rd_data), .misalign_o(misalign), .err_o(err),
      .mem_req_o(req), .mem_we_o(we), .mem_addr_o(maddr), .mem_wdata_o(mwdata),
      .mem_ack_i(ack), .mem_rdata_i(rdata)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      tick(); tick();
      chk("rst_req",      32'(req), 0);
      chk("rst_we",       32'(we), 0);
      chk("rst_misalign", 32'(misalign), 0);
      chk("rst_err",      32'(err), 0);
      chk("rst_addr",     maddr, 0);
      chk("rst_wdata",    mwdata, 0);
      chk("rst_rdata",    rd_data, 0);
      rst = 1'b0;
      #1 chk("idle_stall", 32'(stall), 0);

      // aligned load, ack in first BUSY cycle
      rd = 1'b1; addr = 32'h10;
      #1 chk("ld_idle_stall", 32'(stall), 1);
      tick();
      chk("ld_req", 32'(req), 1);
      chk("ld_addr", maddr, 32'h10);
      chk("ld_we", 32'(we), 0);
      chk("ld_busy_stall", 32'(stall), 1);
      ack = 1'b1; rdata = 32'h1234_5678;
      tick();
      ack = 1'b0;
      chk("ld_done_req", 32'(req), 0);
      chk("ld_done_stall", 32'(stall), 0);
      chk("ld_done_data", rd_data, 32'h1234_5678);
      tick();
      chk("b2b_no_reissue", 32'(req), 0);
      // back-to-back second load starts in the cycle after DONE
      addr = 32'h14;
      #1 chk("b2b_stall", 32'(stall), 1);
      tick();
      chk("b2b_req", 32'(req), 1);
      chk("b2b_addr", maddr, 32'h14);
      ack = 1'b1; rdata = 32'hA5A5_0001;
      tick();
      ack = 1'b0; rd = 1'b0;
      chk("b2b_data", rd_data, 32'hA5A5_0001);
      tick();

      // store with 3-cycle memory
      wr = 1'b1; addr = 32'h20; wdata = 32'hCAFE_F00D;
      tick();
      chk("st_we", 32'(we), 1);
      chk("st_addr", maddr, 32'h20);
      chk("st_wdata1", mwdata, 32'hCAFE_F00D);
      tick();
      chk("st_wdata2", mwdata, 32'hCAFE_F00D);
      chk("st_req2", 32'(req), 1);
      tick();
      chk("st_wdata3", mwdata, 32'hCAFE_F00D);
      chk("st_stall3", 32'(stall), 1);
      ack = 1'b1; rdata = 32'hFFFF_0000;
      tick();
      ack = 1'b0;
      chk("st_done_req", 32'(req), 0);
      chk("st_done_stall", 32'(stall), 0);
      chk("st_data_kept", rd_data, 32'hA5A5_0001);
      wr = 1'b0;
      tick();

      // stray ack in IDLE
      ack = 1'b1; rdata = 32'hFFFF_FFFF;
      tick();
      ack = 1'b0;
      chk("idle_ack_data", rd_data, 32'hA5A5_0001);
      chk("idle_ack_req", 32'(req), 0);

      // watchdog timeout with TIMEOUT=4
      rd = 1'b1; addr = 32'h40;
      tick(); chk("to_busy1", 32'(req), 1);
      tick(); tick(); tick();
      chk("to_busy4_req", 32'(req), 1);
      chk("to_busy4_err", 32'(err), 0);
      tick();
      chk("to_done_req", 32'(req), 0);
      chk("to_err", 32'(err), 1);
      chk("to_data", rd_data, ERR);
      chk("to_done_stall", 32'(stall), 0);
      addr = 32'h44;
      tick();
      chk("to_idle_stall", 32'(stall), 1);
      tick();
      ack = 1'b1; rdata = 32'h0BAD_F00D;
      tick();
      ack = 1'b0; rd = 1'b0;
      chk("after_to_data", rd_data, 32'h0BAD_F00D);
      chk("err_sticky", 32'(err), 1);
      tick();

      // misaligned load and store
      rd = 1'b1; addr = 32'h13;
      #1 chk("mis_stall", 32'(stall), 0);
      tick();
      rd = 1'b0;
      chk("mis_pulse", 32'(misalign), 1);
      chk("mis_req", 32'(req), 0);
      chk("mis_data", rd_data, ERR);
      tick();
      chk("mis_pulse_end", 32'(misalign), 0);
      wr = 1'b1; addr = 32'h22; rdata = 32'h0;
      tick();
      wr = 1'b0;
      chk("mis_st_pulse", 32'(misalign), 1);
      chk("mis_st_req", 32'(req), 0);
      chk("mis_st_data", rd_data, ERR);
      tick();

      // reset in BUSY cycle 2, late ack afterwards
      rd = 1'b1; addr = 32'h50;
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0; rd = 1'b0; ack = 1'b1; rdata = 32'h7777_7777;
      chk("mrst_req", 32'(req), 0);
      chk("mrst_err", 32'(err), 0);
      chk("mrst_addr", maddr, 0);
      chk("mrst_data", rd_data, 0);
      tick();
      ack = 1'b0;
      chk("late_ack_data", rd_data, 0);
      chk("late_ack_req", 32'(req), 0);

      // ack coincides with watchdog expiry: ack wins
      rd = 1'b1; addr = 32'h60;
      tick(); tick(); tick(); tick();
      ack = 1'b1; rdata = 32'h1111_2222;
      tick();
      ack = 1'b0; rd = 1'b0;
      chk("tie_data", rd_data, 32'h1111_2222);
      chk("tie_err", 32'(err), 0);
      chk("tie_req", 32'(req), 0);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
